// File: rtl/sd_emmc_pkg.sv
// Shared definitions for the SD/eMMC CMD-line controller: response types, CRC7
// polynomial, frame geometry and the sequencer state encoding.
package sd_emmc_pkg;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_R1   = 2'b01;
  localparam logic [1:0] RESP_R2   = 2'b10;
  localparam logic [1:0] RESP_R3   = 2'b11;

  // x^7 + x^3 + 1, feedback taps below the implicit x^7 term
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [7:0] CMD_FRAME_LEN = 8'd48;
  localparam logic [7:0] R2_FRAME_LEN  = 8'd136;
  localparam logic [7:0] CMD_CRC_START = 8'd40;
  localparam logic [7:0] R2_HDR_LEN    = 8'd8;
  localparam logic [7:0] R2_CRC_START  = 8'd128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_DONE,
    ST_GAP
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sd_emmc_crc7.sv
// Bit-serial CRC7 (x^7+x^3+1, init 0); shared between the command and response phases.
module sd_emmc_crc7
  import sd_emmc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic fb;

  assign fb = din_i ^ crc_o[6];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_o <= 7'h00;
    end else if (clr_i) begin
      crc_o <= 7'h00;
    end else if (en_i) begin
      crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_emmc_cmd_ctrl.sv
// SD/eMMC CMD-line sequencer: serialises a 48-bit command with CRC7, then captures
// and checks the R1/R2/R3 response or reports a response timeout.
module sd_emmc_cmd_ctrl
  import sd_emmc_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCC_MIN = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         sd_fall_i,
  input  logic         sd_rise_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  output logic         cmd_o,
  output logic         cmd_oe_o,
  input  logic         cmd_i,
  output logic         resp_valid_o,
  output logic [127:0] resp_data_o,
  output logic         resp_crc_err_o,
  output logic         resp_timeout_o
);

  // Handshake: a command is taken on any clk where cmd_valid_i && cmd_ready_o;
  // ready is high only in IDLE, so valid raised while busy has no effect.

  state_t         state_q, state_d;
  logic [7:0]     cnt_q;
  logic [39:0]    tx_sh_q;
  logic [1:0]     type_q;
  logic [127:0]   rx_sh_q, rx_next;
  logic           cmd_q, oe_q, crc_err_q, timeout_q;
  logic           fall, rise, accept;
  logic           crc_clr, crc_en, crc_din, tx_bit, rx_crc_window;
  logic [6:0]     crc;
  logic [2:0]     crc_idx;
  logic [7:0]     last_idx;

  sd_emmc_crc7 u_crc7 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (crc_clr),
    .en_i    (crc_en),
    .din_i   (crc_din),
    .crc_o   (crc)
  );

  assign rise     = sd_rise_i;
  assign fall     = sd_fall_i & ~sd_rise_i;
  assign accept   = cmd_valid_i & (state_q == ST_IDLE);
  assign rx_next  = {rx_sh_q[126:0], cmd_i};
  assign last_idx = (type_q == RESP_R2) ? (R2_FRAME_LEN - 8'd1) : (CMD_FRAME_LEN - 8'd1);
  // CRC bits occupy frame positions 40..46, whose low three bits run 0..6
  assign crc_idx  = 3'd6 - cnt_q[2:0];

  assign rx_crc_window = (type_q == RESP_R2) ? ((cnt_q >= R2_HDR_LEN) && (cnt_q < R2_CRC_START))
                                             : (cnt_q < CMD_CRC_START);

  always_comb begin
    tx_bit = 1'b1;
    if (cnt_q < CMD_CRC_START) begin
      tx_bit = tx_sh_q[39];
    end else if (cnt_q < (CMD_FRAME_LEN - 8'd1)) begin
      tx_bit = crc[crc_idx];
    end
  end

  always_comb begin
    state_d      = state_q;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;
    crc_din      = 1'b0;
    cmd_ready_o  = (state_q == ST_IDLE);
    resp_valid_o = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_TX;
          crc_clr = 1'b1;
        end
      end
      ST_TX: begin
        if (fall) begin
          if (cnt_q == CMD_FRAME_LEN) begin
            state_d = (type_q == RESP_NONE) ? ST_DONE : ST_WAIT;
            crc_clr = 1'b1;
          end else if (cnt_q < CMD_CRC_START) begin
            crc_en  = 1'b1;
            crc_din = tx_sh_q[39];
          end
        end
      end
      ST_WAIT: begin
        if (rise) begin
          if (!cmd_i) begin
            state_d = ST_RX;
            crc_en  = 1'b1;
          end else if (cnt_q == 8'(NCR_MAX - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RX: begin
        if (rise) begin
          crc_en  = rx_crc_window;
          crc_din = cmd_i;
          if (cnt_q == last_idx) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_GAP;
      ST_GAP: begin
        if (fall && (cnt_q == 8'(NCC_MIN - 1))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      tx_sh_q   <= 40'd0;
      type_q    <= RESP_NONE;
      rx_sh_q   <= 128'd0;
      cmd_q     <= 1'b1;
      oe_q      <= 1'b0;
      crc_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tx_sh_q   <= {2'b01, cmd_index_i, cmd_arg_i};
            type_q    <= resp_type_i;
            rx_sh_q   <= 128'd0;
            crc_err_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 8'd0;
          end
        end
        ST_TX: begin
          if (fall) begin
            if (cnt_q == CMD_FRAME_LEN) begin
              cmd_q <= 1'b1;
              oe_q  <= 1'b0;
              cnt_q <= 8'd0;
            end else begin
              cmd_q   <= tx_bit;
              oe_q    <= 1'b1;
              cnt_q   <= sat_inc(cnt_q);
              tx_sh_q <= {tx_sh_q[38:0], 1'b0};
            end
          end
        end
        ST_WAIT: begin
          if (rise) begin
            if (!cmd_i) begin
              rx_sh_q <= rx_next;
              cnt_q   <= 8'd1;
            end else begin
              cnt_q <= sat_inc(cnt_q);
              if (cnt_q == 8'(NCR_MAX - 1)) timeout_q <= 1'b1;
            end
          end
        end
        ST_RX: begin
          if (rise) begin
            rx_sh_q <= rx_next;
            cnt_q   <= sat_inc(cnt_q);
            if (cnt_q == last_idx) begin
              crc_err_q <= (type_q != RESP_R3) && (crc != rx_next[7:1]);
            end
          end
        end
        ST_DONE: cnt_q <= 8'd0;
        ST_GAP: begin
          if (fall) cnt_q <= sat_inc(cnt_q);
        end
        default: cnt_q <= 8'd0;
      endcase
    end
  end

  assign cmd_o          = cmd_q;
  assign cmd_oe_o       = oe_q;
  assign resp_crc_err_o = crc_err_q;
  assign resp_timeout_o = timeout_q;
  assign resp_data_o    = (type_q == RESP_R2) ? rx_sh_q : {90'd0, rx_sh_q[45:8]};

endmodule

// File: tb/tb_sd_emmc_cmd_ctrl.sv
// Bench for sd_emmc_cmd_ctrl: directed and random commands against a card model that
// answers on the CMD line; results are predicted from the frame formats and CRC7 division.
module tb_sd_emmc_cmd_ctrl;

  // clock / reset / SD-clock ticks
  logic         clk = 1'b0;
  logic         rst_n_i;
  logic         sd_fall_i = 1'b0;
  logic         sd_rise_i = 1'b0;
  logic [1:0]   ph = 2'd0;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [5:0]   cmd_index_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   resp_type_i;
  logic         cmd_o;
  logic         cmd_oe_o;
  logic         cmd_i;
  logic         resp_valid_o;
  logic [127:0] resp_data_o;
  logic         resp_crc_err_o;
  logic         resp_timeout_o;

  initial forever #5 clk = ~clk;

  // SD clock = clk/4: fall tick in one clk, rise tick two clks later
  always @(posedge clk) begin
    ph        <= ph + 2'd1;
    sd_fall_i <= (ph == 2'd3);
    sd_rise_i <= (ph == 2'd1);
  end

  sd_emmc_cmd_ctrl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .sd_fall_i      (sd_fall_i),
    .sd_rise_i      (sd_rise_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_index_i    (cmd_index_i),
    .cmd_arg_i      (cmd_arg_i),
    .resp_type_i    (resp_type_i),
    .cmd_o          (cmd_o),
    .cmd_oe_o       (cmd_oe_o),
    .cmd_i          (cmd_i),
    .resp_valid_o   (resp_valid_o),
    .resp_data_o    (resp_data_o),
    .resp_crc_err_o (resp_crc_err_o),
    .resp_timeout_o (resp_timeout_o)
  );

  // scoreboard: {timeout, crc_err, data}
  logic [129:0] exp_q[$];
  int           checks = 0;
  int           passed = 0;
  int           fails  = 0;

  // monitor and card-model state
  logic         tx_q[$];
  logic         card_q[$];
  bit           prev_fall = 0, prev_rise = 0;
  int           fall_total = 0, rise_total = 0, rise_at_end = 0;
  bit           tx_started = 0, txend_seen = 0, card_on = 0, got_valid = 0;
  int           card_delay = 0, card_rises = 0, valid_pulses = 0;
  logic [127:0] got_data;
  logic         got_crc, got_to;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1; msg holds n bits, MSB first
  function automatic logic [6:0] crc7_ref(input logic [127:0] msg, input int n);
    logic [134:0] r;
    r = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r = r ^ (135'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  // One clk, observed at the falling clk edge; also plays the card on cmd_i
  task automatic step();
    @(negedge clk);
    if (prev_fall) begin
      fall_total++;
      if (cmd_oe_o) tx_q.push_back(cmd_o);
    end
    if (prev_rise) rise_total++;
    if (cmd_oe_o) tx_started = 1;
    if (tx_started && !cmd_oe_o && !txend_seen) begin
      txend_seen  = 1;
      rise_at_end = rise_total;
    end
    if (resp_valid_o) begin
      got_valid = 1;
      valid_pulses++;
      got_data = resp_data_o;
      got_crc  = resp_crc_err_o;
      got_to   = resp_timeout_o;
    end
    if (card_on && txend_seen) begin
      if (sd_rise_i) card_rises++;
      if (sd_fall_i && card_rises >= card_delay) begin
        if (card_q.size() > 0) cmd_i = card_q.pop_front();
        else begin
          cmd_i   = 1'b1;
          card_on = 0;
        end
      end
    end
    prev_fall = sd_fall_i;
    prev_rise = sd_rise_i;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready_o && n < 400) begin
      step();
      n++;
    end
  endtask

  logic [47:0] last_tx_frame;

  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                         input bit respond, input int delay, input bit corrupt,
                         input logic [31:0] rarg, input bit poke);
    logic [135:0] frame;
    logic [127:0] exp_data, rnd;
    logic [119:0] cid;
    logic [39:0]  body;
    logic [6:0]   c;
    logic [47:0]  cmd_frame, txf;
    logic [129:0] exp;
    bit           exp_crc, exp_to;
    int           flen, n, k, falls_at_valid, bad;
    body      = {2'b01, idx, arg};
    cmd_frame = {body, crc7_ref({88'd0, body}, 40), 1'b1};
    frame = '0; flen = 0; exp_data = '0; exp_crc = 0; exp_to = 0;
    if (rtype != 2'b00 && !respond) exp_to = 1;
    else if (rtype == 2'b01) begin
      body = {2'b00, idx, rarg};
      c = crc7_ref({88'd0, body}, 40);
      frame = {88'd0, body, c, 1'b1}; flen = 48; exp_data = {90'd0, idx, rarg};
    end else if (rtype == 2'b11) begin
      body = {2'b00, 6'h3F, rarg};
      frame = {88'd0, body, 7'h7F, 1'b1}; flen = 48; exp_data = {90'd0, 6'h3F, rarg};
    end else if (rtype == 2'b10) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cid = rnd[119:0];
      c = crc7_ref({8'd0, cid}, 120);
      frame = {8'h3F, cid, c, 1'b1}; flen = 136; exp_data = frame[127:0];
    end
    if (corrupt && flen > 0) begin
      k = $urandom_range(1, 7);
      frame[k] = ~frame[k];
      if (rtype == 2'b10) exp_data[k] = ~exp_data[k];
      exp_crc = (rtype != 2'b11);
    end
    exp_q.push_back({exp_to, exp_crc, exp_data});
    card_q.delete();
    for (int i = flen - 1; i >= 0; i--) card_q.push_back(frame[i]);
    card_on = (flen > 0); card_delay = delay; card_rises = 0;
    tx_started = 0; txend_seen = 0; tx_q.delete(); got_valid = 0; valid_pulses = 0;

    wait_ready();
    check("ready_before", cmd_ready_o, 1);
    cmd_index_i = idx; cmd_arg_i = arg; resp_type_i = rtype; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0; cmd_index_i = 6'($urandom); cmd_arg_i = $urandom; resp_type_i = 2'($urandom);
    check("ready_drop", cmd_ready_o, 0);

    n = 0;
    while (!got_valid && n < 3000) begin
      if (poke) cmd_valid_i = (n >= 100 && n < 104);
      step();
      n++;
    end
    cmd_valid_i = 1'b0;
    check("resp_valid_seen", got_valid, 1);
    exp = exp_q.pop_front();
    check("resp_data", got_data, exp[127:0]);
    check("resp_crc_err", got_crc, exp[128]);
    check("resp_timeout", got_to, exp[129]);
    check("oe_falls", tx_q.size(), 48);
    txf = '0;
    for (int i = 0; i < tx_q.size() && i < 48; i++) txf = {txf[46:0], tx_q[i]};
    last_tx_frame = txf;
    check("tx_frame", txf, cmd_frame);
    if (exp_to) check("ncr_rises", rise_total - rise_at_end, 64);

    falls_at_valid = fall_total;
    n = 0;
    while (!cmd_ready_o && n < 200) begin
      step();
      n++;
    end
    check("gap_falls", fall_total - falls_at_valid, 8);
    check("valid_pulses", valid_pulses, 1);
    if (poke) begin
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (!cmd_ready_o || cmd_oe_o) bad++;
      end
      check("busy_valid_ignored", bad, 0);
    end
  endtask

  initial begin
    int n;
    rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_index_i = '0; cmd_arg_i = '0;
    resp_type_i = '0; cmd_i = 1'b1;
    step(); step();
    check("rst_ready", cmd_ready_o, 1);
    check("rst_oe", cmd_oe_o, 0);
    check("rst_cmd", cmd_o, 1);
    check("rst_valid", resp_valid_o, 0);
    check("rst_data", resp_data_o, 0);
    check("rst_flags", {resp_crc_err_o, resp_timeout_o}, 0);
    rst_n_i = 1'b1;
    step(); step();

    // CMD0, no response
    run_txn(6'd0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 0);
    check("cmd0_frame", last_tx_frame, 48'h40_0000_0000_95);
    // CMD8 R1, good then corrupted CRC
    run_txn(6'd8, 32'h1AA, 2'b01, 1, 2, 0, 32'h1AA, 0);
    run_txn(6'd8, 32'h1AA, 2'b01, 1, 2, 1, 32'h1AA, 0);
    // CMD55 with silent card
    run_txn(6'd55, $urandom, 2'b01, 0, 0, 0, 32'h0, 0);
    // CMD2 R2, CMD41 R3
    run_txn(6'd2, 32'h0, 2'b10, 1, 5, 0, 32'h0, 0);
    run_txn(6'd41, $urandom, 2'b11, 1, 3, 0, $urandom, 0);
    // start bit on the last allowed rise, plus valid raised while busy
    run_txn(6'd13, $urandom, 2'b01, 1, 63, 0, $urandom, 1);

    // reset mid-frame
    tx_q.delete(); tx_started = 0; txend_seen = 0; card_on = 0;
    wait_ready();
    cmd_index_i = 6'd17; cmd_arg_i = $urandom; resp_type_i = 2'b01; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    n = 0;
    while (tx_q.size() < 20 && n < 1000) begin
      step();
      n++;
    end
    check("reached_bit20", tx_q.size(), 20);
    rst_n_i = 1'b0;
    #1;
    check("midrst_oe", cmd_oe_o, 0);
    check("midrst_cmd", cmd_o, 1);
    check("midrst_ready", cmd_ready_o, 1);
    check("midrst_data", resp_data_o, 0);
    step(); step();
    rst_n_i = 1'b1;
    step();
    run_txn(6'd17, $urandom, 2'b01, 1, 4, 0, $urandom, 0);

    // random traffic
    for (int t = 0; t < 12; t++) begin
      logic [1:0] rt;
      bit         rsp;
      rt  = 2'($urandom_range(0, 3));
      rsp = (rt != 2'b00) && ($urandom_range(0, 4) != 0);
      run_txn(6'($urandom), $urandom, rt, rsp, $urandom_range(0, 30),
              ($urandom_range(0, 3) == 0), $urandom, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
